ascii_hex_parser: RTL and testbench
===================================

Name: ascii_hex_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream.
- Inputs are the one-cycle byte-strobe and the 8-bit data bus.
- Assembles ASCII hex digits into a binary word, terminated by CR or LF.
- Presents the word on a valid/ready interface to the command logic; flags malformed lines and dropped bytes.

Parameters:
- MAX_DIGITS, 8: maximum hex digits per value. Output width W = 4*MAX_DIGITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_done_tick  in  1  one-cycle strobe; din valid this cycle.
- din  in  8  received ASCII byte.
- val_out  out  W  assembled value, right-aligned, zero-extended.
- val_valid  out  1  val_out valid; held until accepted.
- val_ready  in  1  consumer accepts when val_valid && val_ready.
- err_tick  out  1  one-cycle error pulse.
- err_code  out  2  last error: 0 none, 1 invalid char, 2 byte dropped while holding, 3 digit overflow.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All state is registered on posedge clk. rst is sampled only on clk.
- Reset values: state=IDLE, acc=0, count=0, val_out=0, val_valid=0, err_tick=0, err_code=0, busy=0.
- Char classes:
  - digit: 0x30-0x39, 0x41-0x46, 0x61-0x66; nibble = decoded value.
  - term: 0x0D or 0x0A.
  - space: 0x20.
  - all other bytes are invalid.
- Bytes are processed only in cycles where rx_done_tick=1.
- IDLE:
  - term or space: ignored, so CRLF and blank lines yield nothing.
  - digit: acc={0..,nibble}, count=1, go to ACCUM.
  - invalid: error 1, go to DISCARD.
- ACCUM:
  - digit with count<MAX_DIGITS: acc={acc[W-5:0],nibble}, count+1.
  - digit with count==MAX_DIGITS: error 3, go to DISCARD.
  - term: val_out<=acc, val_valid<=1, go to HOLD.
  - space or invalid: error 1, go to DISCARD.
- HOLD:
  - val_valid stays high and val_out stays stable until handshake.
  - Handshake: val_valid<=0 next cycle, go to IDLE, clear acc and count.
  - A byte arriving without handshake in the same cycle: error 2, byte dropped, stay in HOLD.
  - Handshake and byte in the same cycle: the byte is processed with IDLE rules in that cycle; no error.
- DISCARD:
  - Every byte except term is ignored.
  - term: go to IDLE. No value is produced for the errored line.
- Latency: term strobe in cycle N gives val_valid=1 in cycle N+1.
- Errors:
  - err_tick is high for exactly the cycle after the offending strobe.
  - err_code updates in that same cycle and holds until the next error or rst.
  - Errors never assert val_valid.
- Reset mid-line or mid-HOLD: immediate return to reset values. Any pending value is lost.

Optional Feature:
- Macro: ASCII_HEX_PREFIX_EN.
- Defined: the first x/X of a line (0x78/0x58) is accepted when state=ACCUM, count==1 and acc==0. It clears count to 0 and sets a prefix-seen flag.
  - A second prefix is invalid (error 1).
  - A term right after the prefix, with count==0, is error 1 and goes to IDLE with no output.
  - The flag clears on leaving ACCUM.
- Undefined: x/X is an ordinary invalid char (error 1), and the flag logic is absent.

Test Plan:
- Bytes "1A2f\r": 0x31,0x41,0x32,0x66,0x0D; val_ready=1.
  -> val_valid 1 cycle after 0x0D; val_out=0x00001A2F; err_tick never asserted.
- "DEADBEEF\r\n" with val_ready=0 for 20 cycles, then 1.
  -> val_out=0xDEADBEEF held stable throughout; single transfer; the trailing LF is ignored in IDLE, which is reached after handshake.
- "12G4\r5\r".
  -> err_tick once with err_code=1 on 'G'; no value for line 1; then val_out=0x5.
- "123456789\r".
  -> err_code=3 on the 9th digit; no output; next line "7\r" gives val_out=0x7.
- "AB\r" held with val_ready=0, then 'C' strobed.
  -> err_code=2, val_out stays 0xAB. Next, handshake in the same cycle as '9' strobe, then "\r".
  -> no error, val_out=0x9.
- Reset in ACCUM after "FF" (rst high 1 cycle), then "3\r".
  -> all outputs at reset values after reset; val_out=0x3.
  - With ASCII_HEX_PREFIX_EN: "0x1F\r" gives 0x1F.
  - Without the macro: "0x1F\r" gives err_code=1.

Source files
------------

// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser: folds UART ASCII hex digits into a word ended by CR/LF, with valid/ready output and error flags.
// Define ASCII_HEX_PREFIX_EN to accept a leading 0x/0X on each value.
module ascii_hex_parser #(
  parameter int MAX_DIGITS = 8,
  localparam int W = 4*MAX_DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_done_tick,
  input  logic [7:0]   din,
  output logic [W-1:0] val_out,
  output logic         val_valid,
  input  logic         val_ready,
  output logic         err_tick,
  output logic [1:0]   err_code,
  output logic         busy
);
  localparam int CW = $clog2(MAX_DIGITS+1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_DIGITS);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD, S_DISCARD} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d, val_q, val_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [1:0]     code_q, code_d;
  logic           is_dig, is_term, is_space, hs;
  logic [3:0]     nib;
`ifdef ASCII_HEX_PREFIX_EN
  logic           pfx_q, pfx_d, is_x;
  assign is_x = din == 8'h78 || din == 8'h58;
`endif
  assign is_dig   = (din >= 8'h30 && din <= 8'h39) || (din >= 8'h41 && din <= 8'h46) ||
                    (din >= 8'h61 && din <= 8'h66);
  assign is_term  = din == 8'h0D || din == 8'h0A;
  assign is_space = din == 8'h20;
  assign nib      = din[6] ? din[3:0] + 4'd9 : din[3:0];
  assign hs       = state_q == S_HOLD && val_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
`ifdef ASCII_HEX_PREFIX_EN
      pfx_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef ASCII_HEX_PREFIX_EN
      pfx_q   <= pfx_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    err_d   = 1'b0;
    code_d  = code_q;
`ifdef ASCII_HEX_PREFIX_EN
    pfx_d   = pfx_q;
`endif
    case (state_q)
      S_HOLD: begin
        if (hs) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (rx_done_tick) begin
          err_d  = 1'b1;
          code_d = 2'd2;
        end
      end
      S_ACCUM: begin
        if (rx_done_tick) begin
`ifdef ASCII_HEX_PREFIX_EN
          if (is_x && !pfx_q && cnt_q == CW'(1) && acc_q == '0) begin
            cnt_d = '0;
            pfx_d = 1'b1;
          end else
`endif
          if (is_dig && cnt_q < CMAX) begin
            acc_d = {acc_q[W-5:0], nib};
            cnt_d = cnt_q + CW'(1);
          end else if (is_term && cnt_q != '0) begin
            val_d   = acc_q;
            state_d = S_HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = is_dig ? 2'd3 : 2'd1;
            state_d = is_term ? S_IDLE : S_DISCARD;
          end
        end
      end
      S_DISCARD: state_d = rx_done_tick && is_term ? S_IDLE : S_DISCARD;
      default: ;
    endcase
    // A byte landing in IDLE, or together with the handshake, starts a new line
    if (rx_done_tick && (state_q == S_IDLE || hs)) begin
      if (is_dig) begin
        acc_d   = {{(W-4){1'b0}}, nib};
        cnt_d   = CW'(1);
        state_d = S_ACCUM;
      end else if (!is_term && !is_space) begin
        err_d   = 1'b1;
        code_d  = 2'd1;
        state_d = S_DISCARD;
      end
    end
`ifdef ASCII_HEX_PREFIX_EN
    pfx_d = state_d == S_ACCUM && pfx_d;
`endif
  end
  always_comb begin
    val_valid = state_q == S_HOLD;
    busy      = state_q != S_IDLE;
  end
  assign val_out  = val_q;
  assign err_tick = err_q;
  assign err_code = code_q;
endmodule

// File: tb/tb_ascii_hex_parser.sv
// tb_ascii_hex_parser: directed test-plan lines plus random byte traffic against a queue-based line model.
module tb_ascii_hex_parser;
  logic        clk = 1'b0, rst = 1'b1, rx_done_tick = 1'b0, val_ready = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [31:0] val_out;
  logic        val_valid, err_tick, busy;
  logic [1:0]  err_code;
  int          checks = 0, errors = 0;

  ascii_hex_parser dut (
    .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .din(din),
    .val_out(val_out), .val_valid(val_valid), .val_ready(val_ready),
    .err_tick(err_tick), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 collecting digits, 2 value waiting for consumer, 3 skipping a bad line
  int          m_mode;
  int          m_dig[$];
  bit          m_pfx, m_tick;
  logic [1:0]  m_code;
  logic [31:0] m_val;
  string       hu = "0123456789ABCDEF", hl = "0123456789abcdef";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nib_of(input logic [7:0] c);
    for (int i = 0; i < 16; i++) if (c == hu[i] || c == hl[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] line_value();
    logic [31:0] v = 0;
    foreach (m_dig[i]) v = v * 16 + 32'(m_dig[i]);
    return v;
  endfunction

  task automatic m_err(input logic [1:0] c);
    m_tick = 1;
    m_code = c;
  endtask

  task automatic m_step(input logic r, input logic x, input logic [7:0] d, input logic y);
    int  n;
    bit  fresh;
    bit  term;
    if (r) begin
      m_mode = 0; m_dig.delete(); m_pfx = 0; m_tick = 0; m_code = 0; m_val = 0;
      return;
    end
    m_tick = 0;
    n      = nib_of(d);
    term   = d == 8'h0D || d == 8'h0A;
    fresh  = 0;
    case (m_mode)
      0: fresh = x;
      2: if (y) begin m_mode = 0; m_dig.delete(); fresh = x; end
         else if (x) m_err(2);
      1: if (x) begin
`ifdef ASCII_HEX_PREFIX_EN
        if ((d == 8'h78 || d == 8'h58) && !m_pfx && m_dig.size() == 1 && m_dig[0] == 0) begin
          m_dig.delete();
          m_pfx = 1;
        end else
`endif
        if (n >= 0) begin
          if (m_dig.size() < 8) m_dig.push_back(n);
          else begin m_err(3); m_mode = 3; end
        end else if (term) begin
          if (m_dig.size() == 0) begin m_err(1); m_mode = 0; end
          else begin m_val = line_value(); m_mode = 2; end
        end else begin m_err(1); m_mode = 3; end
      end
      default: if (x && term) m_mode = 0;
    endcase
    if (fresh) begin
      if (n >= 0) begin m_dig.delete(); m_dig.push_back(n); m_mode = 1; end
      else if (!term && d != 8'h20) begin m_err(1); m_mode = 3; end
    end
    if (m_mode != 1) m_pfx = 0;
  endtask

  task automatic cyc(input logic r, input logic x, input logic [7:0] d, input logic y);
    rst = r; rx_done_tick = x; din = d; val_ready = y;
    m_step(r, x, d, y);
    @(posedge clk);
    #1;
    check("val_valid", 32'(val_valid), 32'(m_mode == 2));
    check("val_out", val_out, m_val);
    check("err_tick", 32'(err_tick), 32'(m_tick));
    check("err_code", 32'(err_code), 32'(m_code));
    check("busy", 32'(busy), 32'(m_mode != 0));
  endtask

  task automatic send(input string s, input logic y);
    for (int i = 0; i < s.len(); i++) cyc(0, 1, s[i], y);
  endtask

  initial begin
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    check("reset_val", val_out, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    cyc(0, 0, 8'h00, 0);
    send("1A2f\015", 1);
    check("t1_valid", 32'(val_valid), 32'h1);
    check("t1_val", val_out, 32'h00001A2F);
    cyc(0, 0, 8'h00, 1);
    send("DEADBEEF\015", 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 8'h00, 0);
    check("t2_held", val_out, 32'hDEADBEEF);
    check("t2_valid", 32'(val_valid), 32'h1);
    cyc(0, 1, 8'h0A, 1);
    check("t2_idle", 32'(busy), 32'h0);
    send("12G", 1);
    check("t3_code", 32'(err_code), 32'h1);
    send("4\0155\015", 1);
    check("t3_val", val_out, 32'h5);
    cyc(0, 0, 8'h00, 1);
    send("123456789", 1);
    check("t4_code", 32'(err_code), 32'h3);
    send("\0157\015", 1);
    check("t4_val", val_out, 32'h7);
    cyc(0, 0, 8'h00, 1);
    send("AB\015", 0);
    cyc(0, 1, "C", 0);
    check("t5_code", 32'(err_code), 32'h2);
    check("t5_val", val_out, 32'hAB);
    cyc(0, 1, "9", 1);
    check("t5_noerr", 32'(err_tick), 32'h0);
    cyc(0, 1, 8'h0D, 1);
    check("t5_val9", val_out, 32'h9);
    cyc(0, 0, 8'h00, 1);
    send("FF", 1);
    cyc(1, 0, 8'h00, 1);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_val", val_out, 32'h0);
    send("3\015", 1);
    check("t6_val", val_out, 32'h3);
    cyc(0, 0, 8'h00, 1);
    send("0x1F\015", 1);
`ifdef ASCII_HEX_PREFIX_EN
    check("t7_val", val_out, 32'h1F);
`else
    check("t7_code", 32'(err_code), 32'h1);
`endif
    cyc(0, 0, 8'h00, 1);
    for (int k = 0; k < 3000; k++) begin
      int          sel;
      logic [7:0]  b;
      string       alpha = "0123456789ABCDEFabcdef";
      sel = $urandom_range(0, 15);
      b = sel < 8 ? 8'(alpha[$urandom_range(0, 21)]) :
          sel < 10 ? 8'h0D : sel == 10 ? 8'h0A : sel == 11 ? 8'h20 :
          sel == 12 ? 8'h78 : sel == 13 ? 8'h30 : 8'($urandom_range(0, 255));
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0, b, $urandom_range(0, 3) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
